// File: rtl/gomoku_turn_ctrl.sv
// Turn sequencer and move arbiter for the gomoku board: validates, writes and scores one move at a time.
// Optional per-turn idle timeout is built only when GOMOKU_TURN_TIMEOUT_EN is defined.
module gomoku_turn_ctrl #(
   parameter int BOARD_N        = 7,
   parameter int SETTLE_CYCLES  = 2,
   parameter int TIMEOUT_CYCLES = 50_000_000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       new_game,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic [2:0] req_x,
   input  logic [2:0] req_y,
   output logic [2:0] rd_x,
   output logic [2:0] rd_y,
   input  logic [1:0] rd_cell,
   output logic       board_clr,
   output logic       go,
   output logic [2:0] wr_x,
   output logic [2:0] wr_y,
   output logic       wr_color,
   input  logic [1:0] board_state,
   output logic       turn,
   output logic [1:0] winner,
   output logic       game_over,
   output logic       draw,
   output logic [5:0] move_count,
   output logic       illegal,
   output logic       timeout
);

   typedef enum logic [2:0] {
      S_IDLE, S_LOOKUP, S_WRITE, S_SETTLE, S_CHECK, S_OVER, S_CLEAR
   } state_t;

   localparam logic [5:0] CELLS = 6'(BOARD_N * BOARD_N);
   localparam int         SW    = $clog2(SETTLE_CYCLES + 1);

   state_t        state, state_next;
   logic [SW-1:0] settle_cnt;
   logic [2:0]    pos_x, pos_y;
   logic          accept, bad_move, settle_done, tmo_fire;

   assign accept      = (state == S_IDLE) && req_valid && !new_game;
   assign bad_move    = (int'(pos_x) >= BOARD_N) || (int'(pos_y) >= BOARD_N) || (rd_cell != 2'd0);
   assign settle_done = (settle_cnt == SW'(SETTLE_CYCLES - 1));

   assign rd_x      = pos_x;
   assign rd_y      = pos_y;
   assign wr_x      = pos_x;
   assign wr_y      = pos_y;
   assign wr_color  = turn;
   assign req_ready = (state == S_IDLE) && !reset;
   assign board_clr = reset || (state == S_CLEAR);

   always_ff @(posedge clk) begin
      if (reset) state <= S_IDLE;
      else       state <= state_next;
   end

   always_comb begin
      // NOTE: every output of this block gets a default first so no latch is inferred.
      state_next = state;
      go         = 1'b0;
      illegal    = 1'b0;
      if (new_game) begin
         state_next = S_CLEAR;
      end else begin
         case (state)
            S_IDLE:   if (req_valid) state_next = S_LOOKUP;
            S_LOOKUP: begin
               if (bad_move) begin
                  illegal    = 1'b1;
                  state_next = S_IDLE;
               end else begin
                  state_next = S_WRITE;
               end
            end
            S_WRITE: begin
               go         = 1'b1;
               state_next = S_SETTLE;
            end
            S_SETTLE: if (settle_done) state_next = S_CHECK;
            S_CHECK: begin
               if (board_state != 2'd0 || move_count == CELLS) state_next = S_OVER;
               else                                            state_next = S_IDLE;
            end
            S_OVER:   state_next = S_OVER;
            S_CLEAR:  state_next = S_IDLE;
            default:  state_next = S_IDLE;
         endcase
      end
      // A reset cycle mid-move must not leak a strobe to the board.
      if (reset) begin
         go      = 1'b0;
         illegal = 1'b0;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         pos_x      <= '0;
         pos_y      <= '0;
         settle_cnt <= '0;
         turn       <= 1'b0;
         winner     <= 2'd0;
         game_over  <= 1'b0;
         draw       <= 1'b0;
         move_count <= '0;
      end else begin
         if (accept) begin
            pos_x <= req_x;
            pos_y <= req_y;
         end
         if (go) move_count <= move_count + 6'd1;
         if (state == S_SETTLE) settle_cnt <= settle_cnt + SW'(1);
         else                   settle_cnt <= '0;
         if (state == S_CHECK && !new_game) begin
            if (board_state != 2'd0) begin
               winner    <= board_state;
               game_over <= 1'b1;
            end else if (move_count == CELLS) begin
               draw      <= 1'b1;
               game_over <= 1'b1;
            end else begin
               turn <= ~turn;
            end
         end
         if (tmo_fire) turn <= ~turn;
         if (state == S_CLEAR) begin
            turn       <= 1'b0;
            winner     <= 2'd0;
            game_over  <= 1'b0;
            draw       <= 1'b0;
            move_count <= '0;
         end
      end
   end

`ifdef GOMOKU_TURN_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0] tmo_cnt;

   assign tmo_fire = (state == S_IDLE) && !req_valid && !new_game && !reset
                     && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
   assign timeout  = tmo_fire;

   // The idle counter only runs while waiting for a move and restarts on each IDLE entry.
   always_ff @(posedge clk) begin
      if (reset || state != S_IDLE || tmo_fire || new_game) tmo_cnt <= '0;
      else                                                 tmo_cnt <= tmo_cnt + TW'(1);
   end
`else
   assign tmo_fire = 1'b0;
   // TIMEOUT_CYCLES is referenced only to keep the parameter live; the result is constant 0.
   assign timeout  = 1'b0 & (TIMEOUT_CYCLES > 0);
`endif

endmodule

// File: tb/tb_gomoku_turn_ctrl.sv
// Directed self-checking bench for gomoku_turn_ctrl with a behavioural 7x7 board model.
// Timeout steps are checked for the build selected by GOMOKU_TURN_TIMEOUT_EN.
module tb_gomoku_turn_ctrl;

   logic       clk = 1'b0;
   logic       reset, new_game, req_valid;
   logic       req_ready, board_clr, go, wr_color, turn, game_over, draw, illegal, timeout;
   logic [2:0] req_x, req_y, rd_x, rd_y, wr_x, wr_y;
   logic [1:0] rd_cell, board_state, winner;
   logic [5:0] move_count;

   int total = 0;
   int bad = 0;
   int go_count = 0;
   logic [1:0] board [0:6][0:6];

   always #5 clk = ~clk;

   gomoku_turn_ctrl #(.BOARD_N(7), .SETTLE_CYCLES(2), .TIMEOUT_CYCLES(10)) dut (
      .clk(clk), .reset(reset), .new_game(new_game),
      .req_valid(req_valid), .req_ready(req_ready), .req_x(req_x), .req_y(req_y),
      .rd_x(rd_x), .rd_y(rd_y), .rd_cell(rd_cell), .board_clr(board_clr),
      .go(go), .wr_x(wr_x), .wr_y(wr_y), .wr_color(wr_color),
      .board_state(board_state), .turn(turn), .winner(winner),
      .game_over(game_over), .draw(draw), .move_count(move_count),
      .illegal(illegal), .timeout(timeout)
   );

   always @(posedge clk) begin
      if (go === 1'b1) go_count <= go_count + 1;
      if (board_clr === 1'b1) begin
         for (int i = 0; i < 7; i++)
            for (int j = 0; j < 7; j++) board[i][j] <= 2'd0;
      end else if (go === 1'b1 && wr_x < 3'd7 && wr_y < 3'd7) begin
         board[wr_x][wr_y] <= wr_color ? 2'd2 : 2'd1;
      end
   end

   always_comb begin
      rd_cell = 2'd0;
      if (rd_x < 3'd7 && rd_y < 3'd7) rd_cell = board[rd_x][rd_y];
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Starts at a negedge in IDLE; returns at the negedge where the next move may be accepted.
   task automatic move(input logic [2:0] x, input logic [2:0] y, input logic exp_ill,
                       input logic exp_color, input logic exp_turn, input logic [5:0] exp_cnt);
      int g0;
      g0 = go_count;
      check("ready_idle", req_ready, 1);
      req_valid = 1'b1; req_x = x; req_y = y;
      @(negedge clk); req_valid = 1'b0; #1;
      check("lookup_illegal", illegal, exp_ill);
      check("lookup_go", go, 0);
      check("lookup_rd_x", rd_x, x);
      check("lookup_rd_y", rd_y, y);
      check("lookup_ready", req_ready, 0);
      if (exp_ill) begin
         @(negedge clk); #1;
         check("ill_ready_again", req_ready, 1);
         check("ill_no_go", go_count, g0);
         check("ill_turn", turn, exp_turn);
      end else begin
         @(negedge clk); #1;
         check("write_go", go, 1);
         check("write_wr_x", wr_x, x);
         check("write_wr_y", wr_y, y);
         check("write_color", wr_color, exp_color);
         @(negedge clk); #1;
         check("count_cycle3", move_count, exp_cnt);
         check("settle_go", go, 0);
         @(negedge clk); @(negedge clk); @(negedge clk); #1;
         check("turn_cycle6", turn, exp_turn);
         check("one_go", go_count, g0 + 1);
      end
   endtask

   // Pulses new_game at the current negedge; returns at the first IDLE cycle afterwards.
   task automatic new_game_pulse();
      new_game = 1'b1;
      @(negedge clk); new_game = 1'b0; #1;
      check("clr_board_clr", board_clr, 1);
      check("clr_ready", req_ready, 0);
      check("clr_go", go, 0);
      @(negedge clk); #1;
      check("ng_board_clr", board_clr, 0);
      check("ng_ready", req_ready, 1);
      check("ng_turn", turn, 0);
      check("ng_winner", winner, 0);
      check("ng_draw", draw, 0);
      check("ng_game_over", game_over, 0);
      check("ng_count", move_count, 0);
   endtask

   initial begin
      int g0;
      reset = 1'b1; new_game = 1'b0; req_valid = 1'b0;
      req_x = 3'd0; req_y = 3'd0; board_state = 2'd0;

      // Reset state
      repeat (2) @(negedge clk);
      #1;
      check("rst_ready", req_ready, 0);
      check("rst_board_clr", board_clr, 1);
      check("rst_go", go, 0);
      check("rst_illegal", illegal, 0);
      check("rst_timeout", timeout, 0);
      check("rst_turn", turn, 0);
      check("rst_winner", winner, 0);
      check("rst_game_over", game_over, 0);
      check("rst_draw", draw, 0);
      check("rst_count", move_count, 0);
      reset = 1'b0;
      @(negedge clk); #1;
      check("post_rst_ready", req_ready, 1);
      check("post_rst_board_clr", board_clr, 0);

      // Legal move, occupied cell, out-of-range coordinate
      move(3'd3, 3'd3, 1'b0, 1'b0, 1'b1, 6'd1);
      move(3'd3, 3'd3, 1'b1, 1'b1, 1'b1, 6'd1);
      move(3'd7, 3'd0, 1'b1, 1'b1, 1'b1, 6'd1);
      check("count_after_illegal", move_count, 1);

      // new_game during SETTLE aborts the move with no further go
      g0 = go_count;
      req_valid = 1'b1; req_x = 3'd0; req_y = 3'd0;
      @(negedge clk); req_valid = 1'b0;
      @(negedge clk); #1;
      check("abort_go", go, 1);
      check("abort_color", wr_color, 1);
      @(negedge clk); #1;
      check("abort_count", move_count, 2);
      new_game_pulse();
      check("abort_go_total", go_count, g0 + 1);
      check("abort_cell_clear", rd_cell, 0);

      // Black wins on the fifth in-row stone
      for (int i = 0; i < 9; i++) begin
         if (i == 8) board_state = 2'd1;
         move(3'(i % 2), 3'(i / 2), 1'b0, 1'(i % 2),
              (i == 8) ? 1'b0 : 1'((i + 1) % 2), 6'(i + 1));
      end
      check("win_winner", winner, 1);
      check("win_game_over", game_over, 1);
      check("win_draw", draw, 0);
      check("win_ready", req_ready, 0);
      g0 = go_count;
      req_valid = 1'b1; req_x = 3'd5; req_y = 3'd5;
      repeat (6) @(negedge clk);
      req_valid = 1'b0; #1;
      check("over_no_go", go_count, g0);
      check("over_ready", req_ready, 0);
      check("over_count", move_count, 9);
      board_state = 2'd0;
      new_game_pulse();

      // Fill the board with no winner
      for (int i = 0; i < 49; i++) begin
         move(3'(i / 7), 3'(i % 7), 1'b0, 1'(i % 2),
              (i == 48) ? 1'b0 : 1'((i + 1) % 2), 6'(i + 1));
      end
      check("draw_draw", draw, 1);
      check("draw_game_over", game_over, 1);
      check("draw_count", move_count, 49);
      check("draw_winner", winner, 0);
      check("draw_ready", req_ready, 0);
      new_game_pulse();

      // Idle turn behaviour
`ifdef GOMOKU_TURN_TIMEOUT_EN
      for (int k = 0; k < 9; k++) begin
         check("tmo_quiet", timeout, 0);
         @(negedge clk); #1;
      end
      check("tmo_fire", timeout, 1);
      check("tmo_turn_before", turn, 0);
      @(negedge clk); #1;
      check("tmo_turn_after", turn, 1);
      check("tmo_single_pulse", timeout, 0);
      check("tmo_count", move_count, 0);
      check("tmo_ready", req_ready, 1);
`else
      for (int k = 0; k < 12; k++) begin
         check("tmo_off", timeout, 0);
         @(negedge clk); #1;
      end
      check("tmo_off_turn", turn, 0);
      check("tmo_off_ready", req_ready, 1);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
